// File: rtl/hf_decompression.sv
// hf_decompression: serial Huffman decoder. A 16-entry code table (one entry per
// 4-bit symbol) is matched in parallel against the bits received so far. Each
// complete code is emitted as a 4-bit symbol through a valid/ready output register.
// Optional feature macro HF_DEC_STATS_EN: enables the sym_count transfer counter.

// One table entry compared against the candidate code (acc, cnt).
module hf_dec_match #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic [MAX_LEN-1:0] code,
   input  logic [LEN_W-1:0]   len,
   input  logic [MAX_LEN-1:0] acc,
   input  logic [LEN_W-1:0]   cnt,
   output logic               hit
);
   logic [MAX_LEN-1:0] mask;

   // Only the low len bits of the code take part in the compare.
   for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
      assign mask[i] = (len > LEN_W'(i));
   end

   // A zero-length entry can never match, because cnt is at least 1 here.
   assign hit = (len == cnt) && (((code ^ acc) & mask) == '0);
endmodule

module hf_decompression #(
   parameter int  MAX_LEN = 16,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               tbl_clr,
   input  logic               tbl_wr,
   input  logic [3:0]         tbl_sym,
   input  logic [MAX_LEN-1:0] tbl_code,
   input  logic [LEN_W-1:0]   tbl_len,
   output logic               tbl_ready,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               bit_ready,
   output logic [3:0]         hf_d,
   output logic               hf_d_valid,
   input  logic               hf_d_ready,
   output logic               err,
   output logic [15:0]        sym_count
);
   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_ERROR} state_t;

   logic [15:0][LEN_W-1:0]   len_q, len_d;
   logic [15:0][MAX_LEN-1:0] code_q, code_d;
   // A stored partial code is at most MAX_LEN-1 bits, so the top bit is never kept.
   logic [MAX_LEN-2:0]       acc_q, acc_d;
   logic [MAX_LEN-1:0]       acc_n;
   logic [LEN_W-1:0]         cnt_q, cnt_d, cnt_n;
   state_t                   state_q, state_d;
   logic [3:0]               hf_d_q, hf_d_d;
   logic                     hf_d_valid_q, hf_d_valid_d;
   logic                     err_q, err_d;
   logic [15:0]              hit;
   logic [3:0]               hit_sym;
   logic                     accept, xfer;

   assign acc_n      = {acc_q, bit_in};
   assign cnt_n      = cnt_q + LEN_W'(1);
   assign bit_ready  = (state_q != ST_ERROR) && (!hf_d_valid_q || hf_d_ready) && !tbl_clr;
   assign tbl_ready  = (state_q == ST_IDLE) && !hf_d_valid_q;
   assign accept     = bit_valid && bit_ready;
   assign xfer       = hf_d_valid_q && hf_d_ready;
   assign hf_d       = hf_d_q;
   assign hf_d_valid = hf_d_valid_q;
   assign err        = err_q;

   for (genvar g = 0; g < 16; g++) begin : g_match
      hf_dec_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
         .code (code_q[g]),
         .len  (len_q[g]),
         .acc  (acc_n),
         .cnt  (cnt_n),
         .hit  (hit[g])
      );
   end

   // Lowest matching symbol index wins when the table is not prefix-free.
   always_comb begin
      hit_sym = '0;
      for (int i = 15; i >= 0; i--) begin
         if (hit[i]) hit_sym = 4'(i);
      end
   end

   // Next-state: table maintenance, bit accumulation, match/error, and output handshake.
   always_comb begin
      len_d        = len_q;
      code_d       = code_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      state_d      = state_q;
      hf_d_d       = hf_d_q;
      hf_d_valid_d = hf_d_valid_q;
      err_d        = err_q;
      if (xfer) hf_d_valid_d = 1'b0;
      if (tbl_clr) begin
         // The output register is left alone, so a pending symbol is still delivered.
         len_d   = '0;
         acc_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
         state_d = ST_IDLE;
      end else begin
         if (tbl_wr && tbl_ready) begin
            len_d[tbl_sym]  = tbl_len;
            code_d[tbl_sym] = tbl_code;
         end
         if (accept) begin
            if (|hit) begin
               hf_d_d       = hit_sym;
               hf_d_valid_d = 1'b1;
               acc_d        = '0;
               cnt_d        = '0;
               state_d      = ST_IDLE;
            end else if (cnt_n == LEN_W'(MAX_LEN)) begin
               err_d   = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_ERROR;
            end else begin
               acc_d   = acc_n[MAX_LEN-2:0];
               cnt_d   = cnt_n;
               state_d = ST_ACCUM;
            end
         end
      end
   end

   // State and datapath registers; reset invalidates the table and drops any partial code.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         len_q        <= '0;
         code_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         state_q      <= ST_IDLE;
         hf_d_q       <= '0;
         hf_d_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         len_q        <= len_d;
         code_q       <= code_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         hf_d_q       <= hf_d_d;
         hf_d_valid_q <= hf_d_valid_d;
         err_q        <= err_d;
      end
   end

`ifdef HF_DEC_STATS_EN
   logic [15:0] sym_count_q, sym_count_d;

   // Count output transfers; wraps naturally, cleared by tbl_clr.
   always_comb begin
      sym_count_d = sym_count_q;
      if (tbl_clr)   sym_count_d = '0;
      else if (xfer) sym_count_d = sym_count_q + 16'd1;
   end

   // Transfer counter register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) sym_count_q <= '0;
      else        sym_count_q <= sym_count_d;
   end

   assign sym_count = sym_count_q;
`else
   assign sym_count = 16'h0000;
`endif
endmodule

// File: tb/tb_hf_decompression.sv
// Directed bench for hf_decompression: table-driven decode of a short stream plus
// hand-written sequences for backpressure, error, dropped writes, reset and stats.
module tb_hf_decompression;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
`ifdef HF_DEC_STATS_EN
   localparam logic [15:0] EXP_CNT5 = 16'd5;
`else
   localparam logic [15:0] EXP_CNT5 = 16'd0;
`endif

   logic               CLK = 1'b0;
   logic               Reset;
   logic               tbl_clr, tbl_wr;
   logic [3:0]         tbl_sym;
   logic [MAX_LEN-1:0] tbl_code;
   logic [LEN_W-1:0]   tbl_len;
   logic               tbl_ready;
   logic               bit_in, bit_valid, bit_ready;
   logic [3:0]         hf_d;
   logic               hf_d_valid, hf_d_ready;
   logic               err;
   logic [15:0]        sym_count;

   int total = 0;
   int bad   = 0;

   hf_decompression #(.MAX_LEN(MAX_LEN)) dut (
      .CLK(CLK), .Reset(Reset), .tbl_clr(tbl_clr), .tbl_wr(tbl_wr), .tbl_sym(tbl_sym),
      .tbl_code(tbl_code), .tbl_len(tbl_len), .tbl_ready(tbl_ready), .bit_in(bit_in),
      .bit_valid(bit_valid), .bit_ready(bit_ready), .hf_d(hf_d), .hf_d_valid(hf_d_valid),
      .hf_d_ready(hf_d_ready), .err(err), .sym_count(sym_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       b;
      logic       exp_valid;
      logic [3:0] exp_hd;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [3:0] s, input logic [MAX_LEN-1:0] c, input logic [LEN_W-1:0] l);
      tbl_wr = 1'b1; tbl_sym = s; tbl_code = c; tbl_len = l;
      tick();
      tbl_wr = 1'b0;
   endtask

   task automatic load_table();
      wr(4'd0, 16'b0,   5'd1);
      wr(4'd1, 16'b10,  5'd2);
      wr(4'd2, 16'b110, 5'd3);
      wr(4'd3, 16'b111, 5'd3);
   endtask

   task automatic clr_pulse();
      tbl_clr = 1'b1;
      tick();
      tbl_clr = 1'b0;
      #1;
   endtask

   initial begin
      Reset = 1'b0; tbl_clr = 0; tbl_wr = 0; tbl_sym = 0; tbl_code = 0; tbl_len = 0;
      bit_in = 0; bit_valid = 0; hf_d_ready = 1'b1;
      vecs[0] = '{1'b0, 1'b1, 4'd0};
      vecs[1] = '{1'b1, 1'b0, 4'd0};
      vecs[2] = '{1'b0, 1'b1, 4'd1};
      vecs[3] = '{1'b1, 1'b0, 4'd1};
      vecs[4] = '{1'b1, 1'b0, 4'd1};
      vecs[5] = '{1'b0, 1'b1, 4'd2};
      vecs[6] = '{1'b1, 1'b0, 4'd2};
      vecs[7] = '{1'b1, 1'b0, 4'd2};
      vecs[8] = '{1'b1, 1'b1, 4'd3};
      tick(); tick();
      // reset state
      chk("rst_valid", 32'(hf_d_valid), 32'd0);
      chk("rst_hd", 32'(hf_d), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_cnt", 32'(sym_count), 32'd0);
      Reset = 1'b1;
      #1;
      chk("rst_bit_ready", 32'(bit_ready), 32'd1);
      chk("rst_tbl_ready", 32'(tbl_ready), 32'd1);

      // 1: full-throughput decode of 0,10,110,111
      load_table();
      for (int i = 0; i < 9; i++) begin
         bit_valid = 1'b1; bit_in = vecs[i].b;
         tick();
         chk($sformatf("t1_valid[%0d]", i), 32'(hf_d_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("t1_hd[%0d]", i), 32'(hf_d), 32'(vecs[i].exp_hd));
         chk($sformatf("t1_err[%0d]", i), 32'(err), 32'd0);
      end
      bit_valid = 1'b0;
      tick();
      chk("t1_valid_end", 32'(hf_d_valid), 32'd0);

      // 2: backpressure holds the symbol and stalls the bit input
      hf_d_ready = 1'b0;
      bit_valid = 1'b1; bit_in = 1'b1; tick();
      bit_in = 1'b0; tick();
      chk("t2_valid", 32'(hf_d_valid), 32'd1);
      chk("t2_hd", 32'(hf_d), 32'd1);
      chk("t2_bit_ready_lo", 32'(bit_ready), 32'd0);
      tick();
      chk("t2_hold_valid", 32'(hf_d_valid), 32'd1);
      chk("t2_hold_hd", 32'(hf_d), 32'd1);
      hf_d_ready = 1'b1;
      #1;
      chk("t2_bit_ready_hi", 32'(bit_ready), 32'd1);
      tick();
      chk("t2_next_valid", 32'(hf_d_valid), 32'd1);
      chk("t2_next_hd", 32'(hf_d), 32'd0);
      bit_valid = 1'b0; tick();
      chk("t2_drain", 32'(hf_d_valid), 32'd0);

      // 3: empty table errors after MAX_LEN bits; tbl_clr recovers
      clr_pulse();
      bit_valid = 1'b1; bit_in = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         tick();
         chk($sformatf("t3_err[%0d]", i), 32'(err), (i == MAX_LEN - 1) ? 32'd1 : 32'd0);
      end
      chk("t3_bit_ready_lo", 32'(bit_ready), 32'd0);
      chk("t3_valid", 32'(hf_d_valid), 32'd0);
      bit_valid = 1'b0;
      clr_pulse();
      chk("t3_clr_err", 32'(err), 32'd0);
      chk("t3_clr_bit_ready", 32'(bit_ready), 32'd1);

      // 4: table write during ACCUM is dropped
      load_table();
      bit_valid = 1'b1; bit_in = 1'b1; tick(); tick();
      bit_valid = 1'b0;
      tbl_wr = 1'b1; tbl_sym = 4'd0; tbl_code = 16'b1; tbl_len = 5'd1;
      #1;
      chk("t4_tbl_ready", 32'(tbl_ready), 32'd0);
      tick();
      tbl_wr = 1'b0;
      bit_valid = 1'b1; bit_in = 1'b0; tick();
      chk("t4_valid", 32'(hf_d_valid), 32'd1);
      chk("t4_hd", 32'(hf_d), 32'd2);
      bit_valid = 1'b0; tick();
      bit_valid = 1'b1; bit_in = 1'b0; tick();
      chk("t4_s0_valid", 32'(hf_d_valid), 32'd1);
      chk("t4_s0_hd", 32'(hf_d), 32'd0);
      bit_valid = 1'b0; tick();

      // 5: reset mid-code discards the partial code and the table
      bit_valid = 1'b1; bit_in = 1'b1; tick(); tick();
      bit_valid = 1'b0;
      Reset = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(hf_d_valid), 32'd0);
      chk("t5_rst_err", 32'(err), 32'd0);
      chk("t5_rst_hd", 32'(hf_d), 32'd0);
      tick();
      Reset = 1'b1;
      #1;
      bit_valid = 1'b1; bit_in = 1'b0; tick();
      chk("t5_no_out", 32'(hf_d_valid), 32'd0);
      bit_in = 1'b1;
      for (int i = 1; i < MAX_LEN; i++) begin
         tick();
         chk($sformatf("t5_err[%0d]", i), 32'(err), (i == MAX_LEN - 1) ? 32'd1 : 32'd0);
         chk($sformatf("t5_valid[%0d]", i), 32'(hf_d_valid), 32'd0);
      end
      bit_valid = 1'b0;

      // 6: symbol counter and tbl_clr
      clr_pulse();
      chk("t6_clr_err", 32'(err), 32'd0);
      load_table();
      bit_valid = 1'b1; bit_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      bit_valid = 1'b0; tick();
      chk("t6_cnt5", 32'(sym_count), 32'(EXP_CNT5));
      clr_pulse();
      chk("t6_cnt_clr", 32'(sym_count), 32'd0);

      // lowest index wins among duplicate codes
      wr(4'd6, 16'b0, 5'd1);
      wr(4'd3, 16'b0, 5'd1);
      bit_valid = 1'b1; bit_in = 1'b0; tick();
      bit_valid = 1'b0;
      chk("prio_valid", 32'(hf_d_valid), 32'd1);
      chk("prio_hd", 32'(hf_d), 32'd3);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
